time_set_ctrl: RTL and testbench

Sequencing controller for the digital-clock timekeeping datapath. Turns two debounced push-buttons and the 6-bit switch bank into a hour → minute → second editing sequence. Commits the result as a one-cycle load strobe into either the running time counters or the alarm registers. Sits between the board I/O and the timekeeper/alarm logic, and also drives the field-select code the display scanner uses to show edit values.

---
 rtl/clock_pkg.sv | 32 +++
 rtl/time_set_ctrl_if.sv | 35 +++
 rtl/btn_debounce.sv | 58 +++++
 rtl/time_set_ctrl.sv | 162 ++++++++++++++++
 tb/tb_time_set_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types and limits for the digital-clock datapath
//
// Purpose: FSM state encoding, display field codes and time limits shared by
//          time_set_ctrl and the timekeeper, plus clamp helpers.
// Ports:   none (package).
package clock_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOUR,
    S_MIN,
    S_SEC,
    S_COMMIT
  } state_t;

  localparam logic [1:0] FIELD_IDLE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  localparam logic [4:0] MAX_HOUR   = 5'd23;
  localparam logic [5:0] MAX_MINSEC = 6'd59;

  function automatic logic [4:0] clamp_hour(input logic [4:0] v);
    return (v > MAX_HOUR) ? MAX_HOUR : v;
  endfunction

  function automatic logic [5:0] clamp_minsec(input logic [5:0] v);
    return (v > MAX_MINSEC) ? MAX_MINSEC : v;
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// rtl/time_set_ctrl_if.sv - board I/O and load bundle of time_set_ctrl
//
// Purpose: groups the buttons, switch bank, 1 Hz tick and all edit/load
//          outputs of time_set_ctrl.
// Modports:
//   master - board/testbench side: drives btn_time, btn_alarm, sw, tick_1hz;
//            receives edit_field, edit_target, edit_val, load_hour/min/sec,
//            time_load, alarm_load.
//   slave  - time_set_ctrl side: the reverse.
interface time_set_ctrl_if;
  logic       btn_time;
  logic       btn_alarm;
  logic [5:0] sw;
  logic       tick_1hz;
  logic [1:0] edit_field;
  logic       edit_target;
  logic [5:0] edit_val;
  logic [4:0] load_hour;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic       time_load;
  logic       alarm_load;

  modport master (
    output btn_time, btn_alarm, sw, tick_1hz,
    input  edit_field, edit_target, edit_val,
    input  load_hour, load_min, load_sec, time_load, alarm_load
  );

  modport slave (
    input  btn_time, btn_alarm, sw, tick_1hz,
    output edit_field, edit_target, edit_val,
    output load_hour, load_min, load_sec, time_load, alarm_load
  );
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchronise and debounce one push-button
//
// Purpose: two-flop synchroniser followed by a stability counter; the
//          debounced level follows the raw input only after it has held a new
//          value for DB_CYCLES consecutive cycles. fall_pulse is a registered
//          one-cycle pulse the cycle after the debounced level falls.
// Ports:
//   clk        in  system clock
//   clr        in  synchronous active-high reset (level returns to released)
//   raw        in  asynchronous raw button, active-high
//   level      out debounced level
//   fall_pulse out one-cycle release event
module btn_debounce #(
  parameter int DB_CYCLES = 1_250_000
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic level,
  output logic fall_pulse
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      sync_a     <= 1'b0;
      sync_b     <= 1'b0;
      level      <= 1'b0;
      level_d    <= 1'b0;
      fall_pulse <= 1'b0;
      cnt        <= '0;
    end else begin
      sync_a     <= raw;
      sync_b     <= sync_a;
      level_d    <= level;
      fall_pulse <= level_d & ~level;
      // Any return to the current level restarts the stability window.
      if (sync_b != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync_b;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - hour/minute/second edit sequencer for time and alarm
//
// Purpose: turns release events of two debounced buttons plus the switch bank
//          into an hour -> minute -> second edit, then issues a one-cycle load
//          strobe to the time counters (target 0) or alarm registers
//          (target 1). Optional edit timeout when TIME_SET_TIMEOUT_EN is
//          defined; otherwise tick_1hz is unused.
// Ports:
//   clk  in  system clock
//   clr  in  synchronous active-high reset
//   bus  slave modport of time_set_ctrl_if (buttons, sw, tick_1hz in;
//        edit_field/target/val, load_hour/min/sec, time_load, alarm_load out)
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int DB_CYCLES = 1_250_000,
  parameter int TIMEOUT_S = 30
) (
  input logic            clk,
  input logic            clr,
  time_set_ctrl_if.slave bus
);

  state_t     state, state_n;
  logic       target, target_n;
  logic       ev_time, ev_alarm, ev_tgt;
  logic       accept;
  logic       tmo_expire;
  logic       unused_lvl_time, unused_lvl_alarm;
  logic [4:0] hour_r;
  logic [5:0] min_r;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_time (
    .clk        (clk),
    .clr        (clr),
    .raw        (bus.btn_time),
    .level      (unused_lvl_time),
    .fall_pulse (ev_time)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_alarm (
    .clk        (clk),
    .clr        (clr),
    .raw        (bus.btn_alarm),
    .level      (unused_lvl_alarm),
    .fall_pulse (ev_alarm)
  );

  // Only the button that opened the edit may advance it.
  assign ev_tgt = target ? ev_alarm : ev_time;

`ifdef TIME_SET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_S + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_S - 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_expire = bus.tick_1hz && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (clr) begin
      tmo_cnt <= '0;
    end else if (accept || !(state_n inside {S_HOUR, S_MIN, S_SEC})) begin
      tmo_cnt <= '0;
    end else if (bus.tick_1hz) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  localparam int unused_timeout_s = TIMEOUT_S;
  logic unused_tick;
  assign unused_tick = bus.tick_1hz;
  assign tmo_expire  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= S_IDLE;
      target <= 1'b0;
    end else begin
      state  <= state_n;
      target <= target_n;
    end
  end

  always_comb begin
    state_n  = state;
    target_n = target;
    accept   = 1'b0;
    case (state)
      S_IDLE: begin
        // Time wins when both buttons release in the same cycle.
        if (ev_time) begin
          state_n  = S_HOUR;
          target_n = 1'b0;
        end else if (ev_alarm) begin
          state_n  = S_HOUR;
          target_n = 1'b1;
        end
      end
      S_HOUR, S_MIN, S_SEC: begin
        if (ev_tgt) begin
          accept = 1'b1;
          case (state)
            S_HOUR:  state_n = S_MIN;
            S_MIN:   state_n = S_SEC;
            default: state_n = S_COMMIT;
          endcase
        end else if (tmo_expire) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    case (state)
      S_HOUR:  bus.edit_field = FIELD_HOUR;
      S_MIN:   bus.edit_field = FIELD_MIN;
      S_SEC:   bus.edit_field = FIELD_SEC;
      default: bus.edit_field = FIELD_IDLE;
    endcase
  end

  assign bus.edit_target = target;

  // edit_val is clamped for the field that will be current next cycle so the
  // value shown and latched always matches edit_field.
  always_ff @(posedge clk) begin
    if (clr) begin
      bus.edit_val   <= '0;
      hour_r         <= '0;
      min_r          <= '0;
      bus.load_hour  <= '0;
      bus.load_min   <= '0;
      bus.load_sec   <= '0;
      bus.time_load  <= 1'b0;
      bus.alarm_load <= 1'b0;
    end else begin
      case (state_n)
        S_HOUR:       bus.edit_val <= {1'b0, clamp_hour(bus.sw[4:0])};
        S_MIN, S_SEC: bus.edit_val <= clamp_minsec(bus.sw);
        default:      bus.edit_val <= '0;
      endcase
      if (accept) begin
        case (state)
          S_HOUR: hour_r <= bus.edit_val[4:0];
          S_MIN:  min_r  <= bus.edit_val;
          default: begin
            // Final field: publish all three so they are valid in COMMIT.
            bus.load_hour <= hour_r;
            bus.load_min  <= min_r;
            bus.load_sec  <= bus.edit_val;
          end
        endcase
      end
      bus.time_load  <= (state_n == S_COMMIT) && !target;
      bus.alarm_load <= (state_n == S_COMMIT) &&  target;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - scoreboard bench for time_set_ctrl
module tb_time_set_ctrl;

  localparam int DB  = 4;
  localparam int TMO = 3;

  typedef struct {
    logic       is_alarm;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  time_set_ctrl_if bus();

  time_set_ctrl #(.DB_CYCLES(DB), .TIMEOUT_S(TMO)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb_q[$];
  exp_t e;
  logic prev_strobe = 1'b0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic push_exp(input logic a, input int h, input int m, input int s);
    exp_t x;
    x.is_alarm = a;
    x.h = 5'(h);
    x.m = 6'(m);
    x.s = 6'(s);
    sb_q.push_back(x);
  endtask

  // which: 0 = time, 1 = alarm, 2 = both together
  task automatic press(input int which);
    @(negedge clk);
    bus.btn_time  = (which != 1);
    bus.btn_alarm = (which != 0);
    repeat (10) @(negedge clk);
    bus.btn_time  = 1'b0;
    bus.btn_alarm = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic drained(input string name);
    chk(name, sb_q.size(), 0);
  endtask

  // Monitor: every strobe pops one expected commit.
  always @(negedge clk) begin
    if (clr) begin
      prev_strobe = 1'b0;
    end else begin
      if (bus.time_load || bus.alarm_load) begin
        chk("strobe_single_cycle", int'(prev_strobe), 0);
        if (sb_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_strobe: time_load=%0b alarm_load=%0b, expected none",
                   bus.time_load, bus.alarm_load);
        end else begin
          e = sb_q.pop_front();
          chk("alarm_load", int'(bus.alarm_load), int'(e.is_alarm));
          chk("time_load", int'(bus.time_load), int'(!e.is_alarm));
          chk("load_hour", int'(bus.load_hour), int'(e.h));
          chk("load_min", int'(bus.load_min), int'(e.m));
          chk("load_sec", int'(bus.load_sec), int'(e.s));
        end
      end
      prev_strobe = bus.time_load | bus.alarm_load;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_edit_field"}, int'(bus.edit_field), 0);
    chk({tag, "_edit_target"}, int'(bus.edit_target), 0);
    chk({tag, "_edit_val"}, int'(bus.edit_val), 0);
    chk({tag, "_load_hour"}, int'(bus.load_hour), 0);
    chk({tag, "_load_min"}, int'(bus.load_min), 0);
    chk({tag, "_load_sec"}, int'(bus.load_sec), 0);
    chk({tag, "_time_load"}, int'(bus.time_load), 0);
    chk({tag, "_alarm_load"}, int'(bus.alarm_load), 0);
  endtask

  initial begin
    bus.btn_time  = 1'b0;
    bus.btn_alarm = 1'b0;
    bus.sw        = 6'd0;
    bus.tick_1hz  = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    clr = 1'b0;
    repeat (2) @(negedge clk);

    // Time sequence 13:45:07
    press(0);
    chk("t_enter_field", int'(bus.edit_field), 1);
    chk("t_enter_target", int'(bus.edit_target), 0);
    bus.sw = 6'd13;
    press(0);
    chk("t_min_field", int'(bus.edit_field), 2);
    bus.sw = 6'd45;
    press(0);
    chk("t_sec_field", int'(bus.edit_field), 3);
    bus.sw = 6'd7;
    push_exp(1'b0, 13, 45, 7);
    press(0);
    chk("t_done_field", int'(bus.edit_field), 0);
    drained("t_commit_seen");
    chk("t_hold_hour", int'(bus.load_hour), 13);

    // Clamp on alarm edit
    press(1);
    chk("a_enter_target", int'(bus.edit_target), 1);
    bus.sw = 6'd31;
    repeat (2) @(negedge clk);
    chk("a_hour_clamp", int'(bus.edit_val), 23);
    press(1);
    bus.sw = 6'd63;
    repeat (2) @(negedge clk);
    chk("a_min_clamp", int'(bus.edit_val), 59);
    press(1);
    push_exp(1'b1, 23, 59, 59);
    press(1);
    drained("a_commit_seen");

    // Arbitration: simultaneous release, then foreign alarm presses
    press(2);
    chk("arb_field", int'(bus.edit_field), 1);
    chk("arb_target", int'(bus.edit_target), 0);
    bus.sw = 6'd5;
    press(1);
    chk("arb_ignore_hour", int'(bus.edit_field), 1);
    press(0);
    bus.sw = 6'd0;
    press(1);
    chk("arb_ignore_min", int'(bus.edit_field), 2);
    press(0);
    bus.sw = 6'd59;
    push_exp(1'b0, 5, 0, 59);
    press(0);
    drained("arb_commit_seen");

    // Bounce rejection, then a clean 6-cycle press
    for (int i = 0; i < 10; i++) begin
      bus.btn_time = ~bus.btn_time;
      repeat (2) @(negedge clk);
    end
    bus.btn_time = 1'b0;
    repeat (15) @(negedge clk);
    chk("bounce_no_change", int'(bus.edit_field), 0);
    bus.btn_time = 1'b1;
    repeat (6) @(negedge clk);
    bus.btn_time = 1'b0;
    repeat (12) @(negedge clk);
    chk("clean_press_field", int'(bus.edit_field), 1);

    // Timeout: three ticks with no press
    for (int i = 0; i < TMO; i++) begin
      bus.tick_1hz = 1'b1;
      @(negedge clk);
      bus.tick_1hz = 1'b0;
      repeat (3) @(negedge clk);
    end
`ifdef TIME_SET_TIMEOUT_EN
    chk("timeout_field", int'(bus.edit_field), 0);
    press(0);
`else
    chk("no_timeout_field", int'(bus.edit_field), 1);
`endif
    drained("timeout_no_strobe");

    // Reset mid-edit in SEC
    bus.sw = 6'd9;
    press(0);
    press(0);
    chk("pre_clr_field", int'(bus.edit_field), 3);
    clr = 1'b1;
    @(negedge clk);
    chk_all_zero("clr");
    clr = 1'b0;
    press(0);
    chk("restart_field", int'(bus.edit_field), 1);
    chk("restart_target", int'(bus.edit_target), 0);
    bus.sw = 6'd1;
    press(0);
    bus.sw = 6'd2;
    press(0);
    bus.sw = 6'd3;
    push_exp(1'b0, 1, 2, 3);
    press(0);
    drained("restart_commit_seen");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
